// File: rtl/alu_issue_if.sv
`default_nettype none
// ============================================================================
//  Module   : alu_issue_if
//  Purpose  : Upstream (decode input) and downstream (ID/EX output) handshake
//             bundle for the ALU issue stage, including the flush redirect.
//  Revision : 1.0 - initial release
// ============================================================================
interface alu_issue_if #(
  parameter int XLEN = 32
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_rs1_data;
  logic [XLEN-1:0] in_rs2_data;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_in1;
  logic [XLEN-1:0] out_in2;
  logic [3:0]      out_alu_control;
  logic [XLEN-1:0] out_rs2_data;
  logic [4:0]      out_rd;
  logic            out_reg_write;
  logic            out_branch;
  logic [2:0]      out_funct3;
  logic            out_illegal;
  logic [XLEN-1:0] out_pc;

  // Environment side: drives the instruction stream and the execute-stage ready
  modport master (
    output flush, in_valid, in_instr, in_pc, in_rs1_data, in_rs2_data, out_ready,
    input  in_ready, out_valid, out_in1, out_in2, out_alu_control, out_rs2_data,
           out_rd, out_reg_write, out_branch, out_funct3, out_illegal, out_pc
  );

  // Issue stage side
  modport slave (
    input  flush, in_valid, in_instr, in_pc, in_rs1_data, in_rs2_data, out_ready,
    output in_ready, out_valid, out_in1, out_in2, out_alu_control, out_rs2_data,
           out_rd, out_reg_write, out_branch, out_funct3, out_illegal, out_pc
  );
endinterface
`default_nettype wire

// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
//  Module   : alu_issue_stage
//  Purpose  : RV32I decode/issue stage. Turns an instruction plus register
//             read data into ALU operands and op code, held in a valid/ready
//             ID/EX register with stall and flush support.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_issue_stage #(
  parameter int          XLEN     = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic      clk,
  input  logic      rst_n,
  alu_issue_if.slave bus
);

  localparam logic [6:0] c_op_reg    = 7'b0110011;
  localparam logic [6:0] c_op_imm    = 7'b0010011;
  localparam logic [6:0] c_op_lui    = 7'b0110111;
  localparam logic [6:0] c_op_auipc  = 7'b0010111;
  localparam logic [6:0] c_op_load   = 7'b0000011;
  localparam logic [6:0] c_op_store  = 7'b0100011;
  localparam logic [6:0] c_op_branch = 7'b1100011;

  localparam logic [6:0] c_f7_base = 7'b0000000;
  localparam logic [6:0] c_f7_alt  = 7'b0100000;

  localparam logic [3:0] c_alu_and  = 4'b0000;
  localparam logic [3:0] c_alu_or   = 4'b0001;
  localparam logic [3:0] c_alu_add  = 4'b0010;
  localparam logic [3:0] c_alu_xor  = 4'b0011;
  localparam logic [3:0] c_alu_sll  = 4'b0100;
  localparam logic [3:0] c_alu_srl  = 4'b0101;
  localparam logic [3:0] c_alu_sub  = 4'b0110;
  localparam logic [3:0] c_alu_sra  = 4'b0111;
  localparam logic [3:0] c_alu_slt  = 4'b1000;
  localparam logic [3:0] c_alu_sltu = 4'b1001;

  // Instruction fields
  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic [6:0]      w_funct7;
  logic [4:0]      w_rd;
  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_imm_s;
  logic [XLEN-1:0] w_imm_u;
  logic [XLEN-1:0] w_shamt;

  assign w_opcode = bus.in_instr[6:0];
  assign w_rd     = bus.in_instr[11:7];
  assign w_funct3 = bus.in_instr[14:12];
  assign w_funct7 = bus.in_instr[31:25];
  assign w_imm_i  = {{(XLEN-12){bus.in_instr[31]}}, bus.in_instr[31:20]};
  assign w_imm_s  = {{(XLEN-12){bus.in_instr[31]}}, bus.in_instr[31:25], bus.in_instr[11:7]};
  assign w_imm_u  = {bus.in_instr[31:12], 12'b0};
  assign w_shamt  = {{(XLEN-5){1'b0}}, bus.in_instr[24:20]};

  // Decoded next-state values
  logic [XLEN-1:0] w_in1;
  logic [XLEN-1:0] w_in2;
  logic [3:0]      w_alu;
  logic            w_writes;
  logic            w_branch;
  logic            w_illegal;
  logic            w_reg_write;
  logic            w_load;

  // Standard funct3 -> ALU op mapping shared by OP and OP-IMM (funct7 = 0)
  function automatic logic [3:0] base_alu(input logic [2:0] f3);
    case (f3)
      3'b000:  base_alu = c_alu_add;
      3'b001:  base_alu = c_alu_sll;
      3'b010:  base_alu = c_alu_slt;
      3'b011:  base_alu = c_alu_sltu;
      3'b100:  base_alu = c_alu_xor;
      3'b101:  base_alu = c_alu_srl;
      3'b110:  base_alu = c_alu_or;
      default: base_alu = c_alu_and;
    endcase
  endfunction

  // Combinational decode of operands, op code and control flags
  always_comb begin
    w_in1     = '0;
    w_in2     = '0;
    w_alu     = c_alu_add;
    w_writes  = 1'b0;
    w_branch  = 1'b0;
    w_illegal = 1'b0;
    case (w_opcode)
      c_op_reg: begin
        w_in1    = bus.in_rs1_data;
        w_in2    = bus.in_rs2_data;
        w_writes = 1'b1;
        if (w_funct7 == c_f7_base)                         w_alu = base_alu(w_funct3);
        else if (w_funct7 == c_f7_alt && w_funct3 == 3'b000) w_alu = c_alu_sub;
        else if (w_funct7 == c_f7_alt && w_funct3 == 3'b101) w_alu = c_alu_sra;
        else                                                w_illegal = 1'b1;
      end
      c_op_imm: begin
        w_in1    = bus.in_rs1_data;
        w_in2    = w_imm_i;
        w_writes = 1'b1;
        w_alu    = base_alu(w_funct3);
        if (w_funct3 == 3'b001) begin
          w_in2 = w_shamt;
          if (w_funct7 != c_f7_base) w_illegal = 1'b1;
        end else if (w_funct3 == 3'b101) begin
          w_in2 = w_shamt;
          if (w_funct7 == c_f7_alt)       w_alu = c_alu_sra;
          else if (w_funct7 != c_f7_base) w_illegal = 1'b1;
        end
      end
      c_op_lui: begin
        w_in2    = w_imm_u;
        w_writes = 1'b1;
      end
      c_op_auipc: begin
        w_in1    = bus.in_pc;
        w_in2    = w_imm_u;
        w_writes = 1'b1;
      end
      c_op_load: begin
        w_in1    = bus.in_rs1_data;
        w_in2    = w_imm_i;
        w_writes = 1'b1;
      end
      c_op_store: begin
        w_in1 = bus.in_rs1_data;
        w_in2 = w_imm_s;
      end
      c_op_branch: begin
        w_in1    = bus.in_rs1_data;
        w_in2    = bus.in_rs2_data;
        w_branch = 1'b1;
        case (w_funct3)
          3'b000, 3'b001: w_alu = c_alu_sub;   // BEQ/BNE resolved on zero flag
          3'b100, 3'b101: w_alu = c_alu_slt;
          3'b110, 3'b111: w_alu = c_alu_sltu;
          default:        w_illegal = 1'b1;
        endcase
      end
      default: w_illegal = 1'b1;
    endcase
    // An illegal op must not commit architectural side effects downstream
    if (w_illegal) begin
      w_alu    = c_alu_add;
      w_writes = 1'b0;
      w_branch = 1'b0;
    end
  end

  assign w_reg_write  = w_writes && (w_rd != 5'd0);
  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign w_load       = bus.in_valid && bus.in_ready && !bus.flush;

  // ID/EX pipeline register: flush beats load, load beats drain, else hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid       <= 1'b0;
      bus.out_in1         <= '0;
      bus.out_in2         <= '0;
      bus.out_alu_control <= 4'b0000;
      bus.out_rs2_data    <= '0;
      bus.out_rd          <= 5'd0;
      bus.out_reg_write   <= 1'b0;
      bus.out_branch      <= 1'b0;
      bus.out_funct3      <= 3'b000;
      bus.out_illegal     <= 1'b0;
      bus.out_pc          <= RESET_PC;
    end else if (bus.flush) begin
      bus.out_valid <= 1'b0;
    end else if (w_load) begin
      bus.out_valid       <= 1'b1;
      bus.out_in1         <= w_in1;
      bus.out_in2         <= w_in2;
      bus.out_alu_control <= w_alu;
      bus.out_rs2_data    <= bus.in_rs2_data;
      bus.out_rd          <= w_rd;
      bus.out_reg_write   <= w_reg_write;
      bus.out_branch      <= w_branch;
      bus.out_funct3      <= w_funct3;
      bus.out_illegal     <= w_illegal;
      bus.out_pc          <= bus.in_pc;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
Decode/issue stage that feeds the execute-stage ALU. It decodes an RV32I instruction plus register-file read data into the ALU operand pair and the 4-bit ALU operation code. It holds the result in a valid/ready-handshaked ID/EX pipeline register, with stall (backpressure) and flush support. Sits between the register-file read and the ALU.

Parameters:
XLEN, 32, datapath width (only 32 supported)
RESET_PC, 32'h0000_0000, reset value of out_pc

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  squash held and incoming instruction (branch/jump redirect)
in_valid  in  1  upstream instruction valid
in_ready  out  1  stage can accept this cycle
in_instr  in  32  raw instruction
in_pc  in  32  instruction PC
in_rs1_data  in  32  rs1 read data
in_rs2_data  in  32  rs2 read data
out_valid  out  1  ID/EX register holds a live op
out_ready  in  1  execute stage accepts
out_in1  out  32  ALU operand 1
out_in2  out  32  ALU operand 2
out_alu_control  out  4  ALU op code
out_rs2_data  out  32  store data / branch compare source
out_rd  out  5  destination register
out_reg_write  out  1  writes rd (forced 0 when rd==0)
out_branch  out  1  conditional branch
out_funct3  out  3  branch/load/store sub-op
out_illegal  out  1  unsupported opcode/funct
out_pc  out  32  PC of held op

Behaviour:
- Reset (async, rst_n=0): out_valid=0; all data outputs 0; out_pc=RESET_PC. Reset mid-transfer drops the held op.
- ALU code map: AND 0000, OR 0001, ADD 0010, XOR 0011, SLL 0100, SRL 0101, SUB 0110, SRA 0111, SLT 1000, SLTU 1001. Codes 1010-1111 are never emitted.
- Decode, combinational from in_instr:
  - OP (0110011): in1=rs1, in2=rs2. funct3/funct7 select op. funct7=0100000 is valid only with funct3 000 (SUB) or 101 (SRA). Any other funct7 other than 0000000 -> illegal.
  - OP-IMM (0010011): in2 = sign-extended imm[11:0]. Shifts use in2 = {27'b0, shamt}. SLLI needs funct7=0000000; SRLI/SRAI need 0000000/0100000, else illegal. No SUBI.
  - LUI: in1=0, in2={imm[31:12],12'b0}, ADD.
  - AUIPC: in1=in_pc, in2=U-imm, ADD.
  - LOAD/STORE: in1=rs1, in2 = I-imm / S-imm, ADD, reg_write = load only.
  - BRANCH: in1=rs1, in2=rs2, reg_write=0, branch=1. BEQ/BNE -> SUB (execute uses zero_flag). BLT/BGE -> SLT. BLTU/BGEU -> SLTU. funct3 010/011 -> illegal.
  - Any other opcode -> illegal=1, reg_write=0, branch=0, alu_control=ADD, operands 0.
- Handshake:
  - in_ready = !out_valid || out_ready; this is combinational and does not depend on in_valid.
  - Load occurs when in_valid && in_ready && !flush. On load, all out_* fields update on the next edge and out_valid=1.
  - If out_valid && !out_ready, all out_* hold stable (no change while stalled).
  - If out_valid && out_ready && !(in_valid && in_ready), then out_valid goes to 0; data fields may hold.
  - Back-to-back: accept and drain in the same cycle give full throughput, latency 1 cycle.
- Flush: takes priority over everything. Next edge out_valid=0, and the incoming op is not loaded even if in_valid. While flush=1, in_ready still follows the formula, but nothing is captured.
- Illegal ops still flow through with out_valid=1 and out_illegal=1; trap handling is downstream.

Test Plan:
- Reset: assert rst_n=0 mid-stream with out_valid=1 -> out_valid=0 immediately (async), out_pc=RESET_PC, in_ready=1.
- ADD x3,x1,x2 (0x002081B3), rs1=5, rs2=7 -> next cycle out_valid=1, alu_control=0010, in1=5, in2=7, rd=3, reg_write=1; SUB variant 0x402081B3 -> alu_control=0110.
- SRAI x5,x6,3 (0x40335293), rs1=0xF000_0000 -> alu_control=0111, in2=3, rd=5; LUI x1,0x12345 (0x123450B7) -> in1=0, in2=0x1234_5000, alu_control=0010.
- BLTU (funct3=110) -> alu_control=1001, branch=1, reg_write=0, funct3=110; funct3=010 branch -> illegal=1, out_valid=1.
- Backpressure: load op A, hold out_ready=0 for 3 cycles with in_valid=1 and op B presented -> in_ready=0, outputs stay A. Raise out_ready -> A consumed and B loaded the same edge, out_valid stays 1.
- Flush: out_valid=1 and in_valid=1 with flush=1 -> next cycle out_valid=0, incoming op discarded. ADD x0,x1,x2 -> reg_write=0.
